// File: rtl/obi_to_axi4l_bridge.sv
// OBI -> AXI4-Lite master, one outstanding transfer; response pulse 3 cycles after grant minimum.
// Backpressure: gnt only in IDLE; AXI valids hold until their own handshake; B/R accepted only in *_RESP.
module obi_to_axi4l_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [2:0]  AXI_PROT   = 3'b000
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    obi_req_i,
   output logic                    obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
   input  logic                    obi_we_i,
   input  logic [DATA_WIDTH/8-1:0] obi_be_i,
   input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
   output logic                    obi_rvalid_o,
   output logic [DATA_WIDTH-1:0]   obi_rdata_o,
   output logic                    obi_err_o,
   output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
   output logic [2:0]              m_awprot_o,
   output logic                    m_awvalid_o,
   input  logic                    m_awready_i,
   output logic [DATA_WIDTH-1:0]   m_wdata_o,
   output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
   output logic                    m_wvalid_o,
   input  logic                    m_wready_i,
   input  logic [1:0]              m_bresp_i,
   input  logic                    m_bvalid_i,
   output logic                    m_bready_o,
   output logic [ADDR_WIDTH-1:0]   m_araddr_o,
   output logic [2:0]              m_arprot_o,
   output logic                    m_arvalid_o,
   input  logic                    m_arready_i,
   input  logic [DATA_WIDTH-1:0]   m_rdata_i,
   input  logic [1:0]              m_rresp_i,
   input  logic                    m_rvalid_i,
   output logic                    m_rready_o
);

   typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_RESP} state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata;
   logic                    aw_left;
   logic                    w_left;
   logic                    unused_resp;

   // Only resp[1] distinguishes error from success.
   assign unused_resp = m_bresp_i[0] ^ m_rresp_i[0];

   assign obi_gnt_o  = rst_ni && (state == IDLE) && obi_req_i;
   assign m_awaddr_o = addr;
   assign m_araddr_o = addr;
   assign m_awprot_o = AXI_PROT;
   assign m_arprot_o = AXI_PROT;
   assign m_wdata_o  = wdata;
   assign m_wstrb_o  = be;

   always_comb begin
      aw_left = m_awvalid_o && !m_awready_i;
      w_left  = m_wvalid_o && !m_wready_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state        <= IDLE;
         addr         <= '0;
         be           <= '0;
         wdata        <= '0;
         m_awvalid_o  <= 1'b0;
         m_wvalid_o   <= 1'b0;
         m_bready_o   <= 1'b0;
         m_arvalid_o  <= 1'b0;
         m_rready_o   <= 1'b0;
         obi_rvalid_o <= 1'b0;
         obi_err_o    <= 1'b0;
         obi_rdata_o  <= '0;
      end else begin
         obi_rvalid_o <= 1'b0;
         obi_err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (obi_gnt_o) begin
                  addr  <= obi_addr_i;
                  be    <= obi_be_i;
                  wdata <= obi_wdata_i;
                  if (obi_we_i) begin
                     state       <= WR;
                     m_awvalid_o <= 1'b1;
                     m_wvalid_o  <= 1'b1;
                  end else begin
                     state       <= RD_ADDR;
                     m_arvalid_o <= 1'b1;
                  end
               end
            end
            WR: begin
               // AW and W retire independently; a dropped valid marks its channel done.
               m_awvalid_o <= aw_left;
               m_wvalid_o  <= w_left;
               if (!aw_left && !w_left) begin
                  state      <= WR_RESP;
                  m_bready_o <= 1'b1;
               end
            end
            WR_RESP: begin
               if (m_bvalid_i) begin
                  state        <= IDLE;
                  m_bready_o   <= 1'b0;
                  obi_rvalid_o <= 1'b1;
                  obi_err_o    <= m_bresp_i[1];
                  obi_rdata_o  <= '0;
               end
            end
            RD_ADDR: begin
               if (m_arready_i) begin
                  state       <= RD_RESP;
                  m_arvalid_o <= 1'b0;
                  m_rready_o  <= 1'b1;
               end
            end
            RD_RESP: begin
               if (m_rvalid_i) begin
                  state        <= IDLE;
                  m_rready_o   <= 1'b0;
                  obi_rvalid_o <= 1'b1;
                  obi_err_o    <= m_rresp_i[1];
                  obi_rdata_o  <= m_rdata_i;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/obi_to_axi4l_bridge.md
Name: obi_to_axi4l_bridge

Overview:
- Converts the core's OBI data/instruction interface (req/gnt/rvalid) into a single-outstanding AXI4-Lite master.
- One instance per core port; sits directly downstream of the core and drives the SoC AXI4-Lite interconnect.
- Widths default to the SoC AXI4-Lite configuration (32-bit address, 32-bit data).
- Boot fetches from 0x3000_0000 pass through this block unmodified.

Parameters:
ADDR_WIDTH, 32, OBI/AXI address width (matches AXI4L_CONF_ADDR_WIDTH)
DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8 (matches AXI4L_CONF_DATA_WIDTH)
AXI_PROT, 3'b000, constant driven on awprot/arprot (instance for instruction port sets 3'b100)

Ports:
clk_i  in  1  clock, all logic rising-edge
rst_ni  in  1  synchronous active-low reset
obi_req_i  in  1  OBI request
obi_gnt_o  out  1  OBI grant
obi_addr_i  in  ADDR_WIDTH  byte address
obi_we_i  in  1  1=write 0=read
obi_be_i  in  DATA_WIDTH/8  byte enables
obi_wdata_i  in  DATA_WIDTH  write data
obi_rvalid_o  out  1  response valid, one-cycle pulse
obi_rdata_o  out  DATA_WIDTH  read data
obi_err_o  out  1  response error
m_awaddr_o / m_awprot_o / m_awvalid_o  out  ADDR_WIDTH/3/1  AW channel
m_awready_i  in  1  AW ready
m_wdata_o / m_wstrb_o / m_wvalid_o  out  DATA_WIDTH/DATA_WIDTH/8/1  W channel
m_wready_i  in  1  W ready
m_bresp_i / m_bvalid_i  in  2/1  B channel
m_bready_o  out  1  B ready
m_araddr_o / m_arprot_o / m_arvalid_o  out  ADDR_WIDTH/3/1  AR channel
m_arready_i  in  1  AR ready
m_rdata_i / m_rresp_i / m_rvalid_i  in  DATA_WIDTH/2/1  R channel
m_rready_o  out  1  R ready

Behaviour:
- Reset (rst_ni=0 at a rising edge): state=IDLE. All valids, readies, obi_rvalid_o, obi_err_o = 0. obi_rdata_o = 0. Address/data registers = 0.
- obi_gnt_o is forced 0 while rst_ni=0.
- Reset mid-transaction abandons it without a response. The interconnect is reset by the same signal.
- FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_RESP.
- IDLE:
  - obi_gnt_o = obi_req_i (combinational); high only in IDLE.
  - On req&gnt, register addr, we, be, wdata.
  - Next state WR if we=1, else RD_ADDR.
- WR:
  - m_awvalid_o and m_wvalid_o both assert in the first WR cycle, from registers.
  - Each deasserts in the cycle after its own handshake.
  - Valids never drop before their handshake.
  - Handshakes may complete in the same cycle or in either order.
  - m_wstrb_o = registered be; m_awaddr_o = registered addr, unaligned bits passed through.
  - When both handshakes are done, go to WR_RESP.
- WR_RESP: m_bready_o = 1. On bvalid, go to IDLE.
- RD_ADDR: m_arvalid_o = 1 until arready, then go to RD_RESP.
- RD_RESP: m_rready_o = 1. On rvalid, capture rdata/rresp and go to IDLE.
- Response:
  - In the cycle after the B or R handshake: obi_rvalid_o = 1 for exactly one cycle.
  - obi_err_o = resp[1] (SLVERR/DECERR → 1, OKAY/EXOKAY → 0).
  - obi_rdata_o = captured rdata for reads, 0 for writes.
  - obi_rdata_o holds its value until the next response; obi_err_o is 0 when rvalid_o = 0.
- A new grant may occur in the same cycle obi_rvalid_o is high (state already IDLE).
- Ordering and limits:
  - Exactly one outstanding transaction; responses stay in request order.
  - A B/R beat outside the matching *_RESP state is ignored; ready is low.
- Min latency, all readies=1:
  - Read: gnt T0, AR T1, R T2, obi_rvalid_o T3.
  - Write: gnt T0, AW+W T1, B T2, obi_rvalid_o T3.
- awprot/arprot = AXI_PROT constantly.

Test Plan:
- Read, all readies=1, slave returns rdata=0xDEAD_BEEF OKAY, addr 0x3000_0004 → araddr=0x3000_0004 at T1, obi_rvalid_o at T3 only, rdata=0xDEAD_BEEF, err=0.
- Write addr 0x1000_0008, wdata 0x1234_5678, be=4'b0011; awready delayed 3 cycles, wready=1 → wvalid drops T2, awvalid held to T4, wstrb=0x3; B OKAY → single rvalid pulse, rdata=0, err=0.
- W accepted before AW and AW before W (both orderings, 0–5 cycle skews) → exactly one AW and one W handshake each, no re-issue, one response.
- Read with rresp=2'b10, then write with bresp=2'b11 → obi_err_o=1 on both pulses; next read OKAY → err=0.
- Back-to-back reads with req held high → second gnt in same cycle as first rvalid_o; never two outstanding ARs.
- Assert rst_ni=0 during RD_RESP with arvalid done → all outputs 0 next cycle, no obi_rvalid_o, gnt=0 during reset; after release, new read completes normally.
